// File: rtl/demux_sched_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 8-way round-robin demux scheduler.
package demux_sched_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic [NCH-1:0] onehot8(input logic [SEL_W-1:0] s);
    logic [NCH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_rr_sched_rr_pick8.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping mod 8.
module rr_pick8
  import demux_sched_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    // Rotate so that bit 0 of rot is the channel at ptr; lowest set bit wins.
    dbl   = {req, req} >> ptr;
    rot   = dbl[NCH-1:0];
    found = 1'b0;
    off   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i[SEL_W-1:0];
      end
    end
    idx = ptr + off;
  end

endmodule

// File: rtl/demux_rr_sched.sv
// One-word buffered 1-to-8 demux scheduler, work-conserving round-robin over enabled ready channels.
// Word accepted at edge N is offered in cycle N+1; refill allowed in the same cycle as delivery.
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STALL_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [NCH-1:0]    ch_ready,
  output logic [NCH-1:0]    ch_valid,
  output logic [DATA_W-1:0] ch_data,
  output logic [SEL_W-1:0]  sel,
  output logic              stall,
  output logic [15:0]       xfer_cnt
);

  localparam logic [15:0] STALL_LIM = 16'(STALL_MAX);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [15:0]       xfer_q, xfer_d;
  logic [15:0]       scnt_q, scnt_d;
  logic              stall_q, stall_d;

  logic              full, found, out_fire, in_fire;
  logic [SEL_W-1:0]  pick_idx;

  rr_pick8 u_pick (
    .req   (en_mask & ch_ready),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  assign full     = (state_q == FULL);
  assign out_fire = full & found;
  assign in_ready = ~full | out_fire;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    xfer_d  = xfer_q;
    scnt_d  = scnt_q;
    stall_d = stall_q;

    if (in_fire) begin
      data_d  = in_data;
      state_d = FULL;
    end else if (out_fire) begin
      state_d = EMPTY;
    end

    if (out_fire) begin
      ptr_d   = pick_idx + 3'd1;
      sel_d   = pick_idx;
      xfer_d  = xfer_q + 16'd1;
      scnt_d  = '0;
      stall_d = 1'b0;
    end else if (full) begin
      // Held word with no taker: count toward the stall threshold, saturating.
      scnt_d = (scnt_q == STALL_LIM) ? scnt_q : scnt_q + 16'd1;
      if (scnt_d == STALL_LIM) stall_d = 1'b1;
    end else begin
      scnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      xfer_q  <= '0;
      scnt_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      xfer_q  <= xfer_d;
      scnt_q  <= scnt_d;
      stall_q <= stall_d;
    end
  end

  assign ch_valid = out_fire ? onehot8(pick_idx) : '0;
  assign sel      = out_fire ? pick_idx : sel_q;
  assign ch_data  = data_q;
  assign stall    = stall_q;
  assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: constant vector table, directed corner sequences, random run vs. reference model.
module tb_demux_rr_sched;

  localparam int DW   = 8;
  localparam int SMAX = 16;

  logic          clk;
  logic          rst_n;
  logic [7:0]    en_mask;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [7:0]    ch_ready;
  logic [7:0]    ch_valid;
  logic [DW-1:0] ch_data;
  logic [2:0]    sel;
  logic          stall;
  logic [15:0]   xfer_cnt;

  demux_rr_sched #(.DATA_W(DW), .STALL_MAX(SMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_mask  (en_mask),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ch_ready (ch_ready),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .sel      (sel),
    .stall    (stall),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue-of-one buffer plus a pointer, scanned by plain offset arithmetic.
  bit         m_full;
  logic [7:0] m_data;
  int         m_ptr, m_sel, m_xfer, m_scnt;
  bit         m_stall;

  function automatic int pick(input logic [7:0] en, input logic [7:0] rdy, input int p);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (p + k) % 8;
      if (en[c] && rdy[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = '0; m_ptr = 0; m_sel = 0; m_xfer = 0; m_scnt = 0; m_stall = 0;
  endtask

  task automatic model_check();
    int         c;
    logic [7:0] v;
    c = m_full ? pick(en_mask, ch_ready, m_ptr) : -1;
    v = '0;
    if (c >= 0) v[c] = 1'b1;
    chk("m_ch_valid", ch_valid, v);
    chk("m_sel", sel, (c >= 0) ? c : m_sel);
    chk("m_in_ready", in_ready, (!m_full || c >= 0) ? 1 : 0);
    chk("m_ch_data", ch_data, m_data);
    chk("m_stall", stall, m_stall);
    chk("m_xfer_cnt", xfer_cnt, m_xfer);
  endtask

  task automatic model_update();
    int c;
    bit ofire, ifire;
    c     = m_full ? pick(en_mask, ch_ready, m_ptr) : -1;
    ofire = (c >= 0);
    ifire = in_valid && (!m_full || ofire);
    if (ofire) begin
      m_ptr = (c + 1) % 8; m_sel = c; m_xfer = (m_xfer + 1) % 65536;
      m_scnt = 0; m_stall = 0;
    end else if (m_full) begin
      if (m_scnt < SMAX) m_scnt++;
      if (m_scnt == SMAX) m_stall = 1;
    end else begin
      m_scnt = 0;
    end
    if (ifire) m_data = in_data;
    m_full = ifire || (m_full && !ofire);
  endtask

  // Inputs change at posedge+1; outputs are sampled at the negedge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic fin();
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    settle();
    fin();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_ch_data", ch_data, 0);
    chk("rst_stall", stall, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] en, rdy;
    logic       vld;
    logic [7:0] dat;
    logic [7:0] e_vld;
    logic [2:0] e_sel;
    logic       e_rdy;
    logic [7:0] e_dat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    rst_n = 1'b0; en_mask = '0; ch_ready = '0; in_valid = 1'b0; in_data = '0;
    model_reset();
    #2;

    // Skip not-ready channels: ch_ready=1010_0100 from ptr 0 gives 2,5,7,2.
    tbl[0] = '{8'hFF, 8'hA4, 1'b1, 8'h51, 8'h00, 3'd0, 1'b1, 8'h00};
    tbl[1] = '{8'hFF, 8'hA4, 1'b1, 8'h52, 8'h04, 3'd2, 1'b1, 8'h51};
    tbl[2] = '{8'hFF, 8'hA4, 1'b1, 8'h53, 8'h20, 3'd5, 1'b1, 8'h52};
    tbl[3] = '{8'hFF, 8'hA4, 1'b1, 8'h54, 8'h80, 3'd7, 1'b1, 8'h53};
    tbl[4] = '{8'hFF, 8'hA4, 1'b0, 8'h00, 8'h04, 3'd2, 1'b1, 8'h54};
    tbl[5] = '{8'hFF, 8'hA4, 1'b0, 8'h00, 8'h00, 3'd2, 1'b1, 8'h54};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      en_mask = tbl[i].en; ch_ready = tbl[i].rdy; in_valid = tbl[i].vld; in_data = tbl[i].dat;
      settle();
      chk("tbl_ch_valid", ch_valid, tbl[i].e_vld);
      chk("tbl_sel", sel, tbl[i].e_sel);
      chk("tbl_in_ready", in_ready, tbl[i].e_rdy);
      chk("tbl_ch_data", ch_data, tbl[i].e_dat);
      fin();
    end

    // Reset while FULL discards the buffered word.
    do_reset();
    en_mask = 8'h00; ch_ready = 8'hFF; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    in_valid = 1'b0;
    tick();
    do_reset();
    en_mask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_no_deliver", ch_valid, 0);
      fin();
    end

    // Round-robin full rate.
    do_reset();
    en_mask = 8'hFF; ch_ready = 8'hFF;
    for (int i = 0; i <= 16; i++) begin
      in_valid = (i < 16); in_data = 8'(8'h10 + i);
      settle();
      chk("rr_in_ready", in_ready, 1);
      if (i > 0) begin
        chk("rr_sel", sel, (i - 1) % 8);
        chk("rr_ch_data", ch_data, 8'h10 + i - 1);
      end
      fin();
    end
    in_valid = 1'b0;
    settle();
    chk("rr_xfer_cnt", xfer_cnt, 16);
    fin();

    // Mask change while held, stall assert and clear.
    do_reset();
    en_mask = 8'h00; ch_ready = 8'hFF; in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      settle();
      chk("hold_ch_valid", ch_valid, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stall_early", stall, 0);
      fin();
    end
    en_mask = 8'h08;
    settle();
    chk("mask_stall_set", stall, 1);
    chk("mask_ch_valid", ch_valid, 8'h08);
    chk("mask_ch_data", ch_data, 8'hA5);
    chk("mask_sel", sel, 3);
    fin();
    settle();
    chk("mask_stall_clr", stall, 0);
    chk("mask_empty_vld", ch_valid, 0);
    fin();

    // Simultaneous accept and deliver: no bubble.
    do_reset();
    en_mask = 8'hFF; ch_ready = 8'hFF; in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h3C;
    settle();
    chk("sim_in_ready", in_ready, 1);
    chk("sim_ch_valid0", ch_valid, 8'h01);
    fin();
    in_valid = 1'b0;
    settle();
    chk("sim_ch_data", ch_data, 8'h3C);
    chk("sim_ch_valid1", ch_valid, 8'h02);
    fin();

    // Pointer wrap 7 -> 0 with en_mask=8'h81.
    do_reset();
    en_mask = 8'h40; ch_ready = 8'hFF; in_valid = 1'b1; in_data = 8'h70;
    tick();
    in_valid = 1'b0;
    tick();
    en_mask = 8'h81;
    for (int i = 0; i <= 4; i++) begin
      in_valid = (i < 4); in_data = 8'(8'h71 + i);
      settle();
      if (i > 0) chk("wrap_sel", sel, (i % 2 == 1) ? 7 : 0);
      fin();
    end
    in_valid = 1'b0;
    tick();

    // Delivery counter wrap: 65535 deliveries, then one more.
    do_reset();
    en_mask = 8'hFF; ch_ready = 8'hFF; in_valid = 1'b1; in_data = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    settle();
    chk("xfer_max", xfer_cnt, 16'hFFFF);
    fin();
    settle();
    chk("xfer_wrap", xfer_cnt, 0);
    fin();

    // Randomized run against the reference model.
    do_reset();
    for (int blk = 0; blk < 120; blk++) begin
      int len;
      len = $urandom_range(4, 30);
      en_mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      for (int j = 0; j < len; j++) begin
        ch_ready = 8'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        if ($urandom_range(0, 9) == 0) en_mask = 8'($urandom);
        tick();
      end
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
- Sequential scheduler for an 8-way 1-to-N demultiplexing datapath.
- Accepts a single valid/ready input word stream and buffers one word.
- Delivers each word to one of 8 output channels, using work-conserving round-robin over enabled, ready channels.
- Drives the 3-bit channel select and the per-channel one-hot valid. Sits between a producer and 8 consumer channels.

Parameters:
- DATA_W, 8, width of data word.
- STALL_MAX, 16, consecutive no-delivery cycles with buffered word before stall flag asserts (1..65535).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_mask  input  8  per-channel enable; bit i=1 allows channel i as destination.
- in_valid  input  1  producer word valid.
- in_data  input  DATA_W  producer word.
- in_ready  output  1  block can accept a word this cycle.
- ch_ready  input  8  per-channel consumer ready.
- ch_valid  output  8  one-hot (or zero) valid toward selected channel.
- ch_data  output  DATA_W  shared data bus to all channels (buffered word).
- sel  output  3  index of channel currently offered the word.
- stall  output  1  sticky stall indication.
- xfer_cnt  output  16  count of completed deliveries, wraps 65535->0.

Behaviour:
- Reset (async assert, sync release) sets all state to zero:
  - state=EMPTY, buffer invalid, ptr=0, sel=0, ch_valid=0, ch_data=0, stall=0, xfer_cnt=0, stall counter=0.
  - Reset mid-operation discards any buffered word.
- States:
  - EMPTY: no word held.
  - FULL: one word held in the data register.
- Accept rule: in_fire = in_valid & in_ready.
  - in_ready = (state==EMPTY) | out_fire. Pass-through refill is allowed in the same cycle as delivery.
- Pick rule (combinational, evaluated every cycle in FULL):
  - Candidate = first index i scanning ptr, ptr+1, ... ptr+7 (mod 8) with en_mask[i] & ch_ready[i].
  - found=1 if any such index exists.
- Outputs in FULL:
  - sel = candidate when found, else sel holds its last registered value.
  - ch_valid = onehot(candidate) when found, else 8'h00.
  - In EMPTY: ch_valid=0 and sel holds.
  - ch_valid is never multi-hot.
- Delivery: out_fire = (state==FULL) & found. Because ch_ready is part of the pick, the transfer completes in that cycle.
  - On out_fire: ptr <= candidate+1 (mod 8, 7 wraps to 0); sel register <= candidate; xfer_cnt <= xfer_cnt+1.
- Transitions:
  - EMPTY + in_fire -> FULL; data register <= in_data.
  - FULL + out_fire & ~in_fire -> EMPTY.
  - FULL + out_fire & in_fire -> FULL; data register <= new in_data.
  - FULL + ~out_fire -> FULL; word held, in_ready=0.
- Latency: word accepted at edge N is offered on ch_data/ch_valid in cycle N+1. Minimum 1 cycle. Sustained throughput is 1 word/cycle when any enabled channel is ready.
- ch_data is registered and changes only on in_fire.
- en_mask and ch_ready are sampled live. A mask change takes effect in the same cycle's pick, and the buffered word is never dropped.
- en_mask==0 in FULL: no delivery, word held indefinitely, stall counter runs.
- Stall counter:
  - Increments each FULL cycle without out_fire, saturating at STALL_MAX.
  - Clears on out_fire or in EMPTY.
  - stall <= 1 when the counter reaches STALL_MAX; stall clears on the next out_fire.
- ptr does not move without a delivery. Channels that are not ready are skipped, not waited on.

Decomposition:
- Package demux_sched_pkg:
  - NCH=8 and SEL_W=3 constants.
  - State enum {EMPTY, FULL}.
  - Function onehot8(sel).
- Sub-module rr_pick8: combinational rotating-priority picker.
  - Inputs: req[7:0] (= en_mask & ch_ready), ptr[2:0].
  - Outputs: found, idx[2:0].
- Top holds the FSM, data register, ptr, counters and stall logic.

Test Plan:
- Reset/idle: assert rst_n=0 mid-transfer with FULL state -> next cycle all outputs 0, in_ready=1, xfer_cnt=0; buffered word not delivered after release.
- Round-robin full rate: en_mask=8'hFF, ch_ready=8'hFF, stream 16 words 0x10..0x1F back-to-back -> sel sequence 0,1,...,7,0,...,7; one word per cycle; in_ready stays 1; xfer_cnt=16.
- Skip not-ready: en_mask=8'hFF, ch_ready=8'b1010_0100, ptr=0 -> words go to channels 2,5,7,2 in order; ch_valid=8'h04, 8'h20, 8'h80, 8'h04.
- Mask change while held: en_mask=8'h00, send word 0xA5 -> ch_valid=0, in_ready=0. After 16 cycles stall=1. Set en_mask=8'h08 -> same cycle ch_valid=8'h08, ch_data=0xA5, sel=3; stall clears next edge.
- Simultaneous in/out: FULL with delivery cycle and in_valid=1 data 0x3C -> in_ready=1 that cycle; next cycle ch_data=0x3C, state FULL, no bubble.
- Wrap: ptr=7, en_mask=8'h81, ch_ready=8'hFF -> deliveries alternate sel 7,0,7,0; xfer_cnt preloaded via 65535 deliveries +1 -> wraps to 0.
